// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmitter peripheral: register offsets,
// STATUS/CTRL bit positions, TX state encoding and reset divisor.
package uart_tx_dev_pkg;

   localparam logic [1:0] UART_DATA   = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_CTRL   = 2'd2;
   localparam logic [1:0] UART_DIV    = 2'd3;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_CNT   = 4;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;

   // 50 MHz / 115200 baud
   localparam logic [15:0] DIV_DEFAULT = 16'd434;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: circular buffer, power-of-two depth.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter  int FIFO_DEPTH = 8,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, byte FIFO, TX FSM and baud timer.
//   state    | meaning
//   ST_IDLE  | line high; pops the FIFO head when enabled and data is queued
//   ST_START | start bit (low) for one bit time
//   ST_DATA  | eight data bits, LSB first, one bit time each
//   ST_STOP  | stop bit (high) for one bit time
module uart_tx_dev #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DIV_DEFAULT = uart_tx_dev_pkg::DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        txd,
   output logic        IRQ
);
   import uart_tx_dev_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e     state, state_d;
   logic [7:0]    shifter, shifter_d;
   logic [2:0]    bit_cnt, bit_cnt_d;
   logic [15:0]   baud_cnt, baud_cnt_d;
   logic [15:0]   divisor, div_eff;
   logic          ctrl_en, ctrl_irq_en, overflow;
   logic          txd_d, bit_end;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [1:0]    reg_sel;
   logic          wr_data, wr_status, wr_ctrl, wr_div;
   logic          unused_bits;

   assign reg_sel     = Addr[3:2];
   assign wr_data     = WE & (reg_sel == UART_DATA);
   assign wr_status   = WE & (reg_sel == UART_STATUS);
   assign wr_ctrl     = WE & (reg_sel == UART_CTRL);
   assign wr_div      = WE & (reg_sel == UART_DIV);
   assign unused_bits = ^{Addr[31:4], Din[31:16]};

   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_data),
      .din   (Din[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         divisor     <= DIV_DEFAULT;
         overflow    <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en     <= Din[CTRL_EN];
            ctrl_irq_en <= Din[CTRL_IRQ_EN];
         end
         if (wr_div) divisor <= Din[15:0];
         if (wr_status) overflow <= 1'b0;
         else if (wr_data && fifo_full && !fifo_pop) overflow <= 1'b1;
      end
   end

   // Divisor is compared live, so >= ends the bit promptly if it shrinks mid-bit.
   assign div_eff = (divisor == 16'd0) ? 16'd1 : divisor;
   assign bit_end = (baud_cnt >= div_eff - 16'd1);

   always_comb begin
      state_d    = state;
      shifter_d  = shifter;
      bit_cnt_d  = bit_cnt;
      baud_cnt_d = baud_cnt;
      fifo_pop   = 1'b0;
      if (state != ST_IDLE) baud_cnt_d = bit_end ? 16'd0 : baud_cnt + 16'd1;
      case (state)
         ST_IDLE: begin
            if (ctrl_en && !fifo_empty) begin
               fifo_pop   = 1'b1;
               shifter_d  = fifo_dout;
               baud_cnt_d = 16'd0;
               bit_cnt_d  = 3'd0;
               state_d    = ST_START;
            end
         end
         ST_START: if (bit_end) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_end) begin
               shifter_d = {1'b0, shifter[7:1]};
               bit_cnt_d = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: if (bit_end) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // txd is registered from the next state so the line never glitches.
      txd_d = 1'b1;
      if (state_d == ST_START) txd_d = 1'b0;
      else if (state_d == ST_DATA) txd_d = shifter_d[0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         shifter  <= 8'd0;
         bit_cnt  <= 3'd0;
         baud_cnt <= 16'd0;
         txd      <= 1'b1;
      end else begin
         state    <= state_d;
         shifter  <= shifter_d;
         bit_cnt  <= bit_cnt_d;
         baud_cnt <= baud_cnt_d;
         txd      <= txd_d;
      end
   end

   assign IRQ = ctrl_irq_en & ctrl_en & fifo_empty & (state == ST_IDLE);

   always_comb begin
      Dout = 32'd0;
      case (reg_sel)
         UART_STATUS: begin
            Dout[STAT_BUSY]       = (state != ST_IDLE);
            Dout[STAT_FULL]       = fifo_full;
            Dout[STAT_EMPTY]      = fifo_empty;
            Dout[STAT_OVF]        = overflow;
            Dout[STAT_CNT +: CW]  = fifo_count;
         end
         UART_CTRL: Dout[1:0]  = {ctrl_irq_en, ctrl_en};
         UART_DIV:  Dout[15:0] = divisor;
         default:   Dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed/randomised bench for uart_tx_dev; txd is compared against a
// frame model built from the 8N1 bit pattern and the programmed divisor.
module tb_uart_tx_dev;
   import uart_tx_dev_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:2] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        txd;
   logic        IRQ;

   int n_chk = 0;
   int n_pass = 0;
   byte unsigned exp_q[$];

   uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_DEFAULT(16'd434)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
      .Dout(Dout), .txd(txd), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Upper address bits are randomised: the block must ignore them.
   task automatic sel(input logic [1:0] off);
      Addr = {28'($urandom), off};
   endtask

   task automatic bus_wr(input logic [1:0] off, input logic [31:0] d);
      @(negedge clk);
      sel(off);
      Din = d;
      WE  = 1'b1;
      @(posedge clk);
      #1 WE = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] off, input string tag, input logic [31:0] exp);
      sel(off);
      #1;
      chk(tag, Dout, exp);
   endtask

   function automatic logic frame_bit(input byte unsigned b, input int k, input int d);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      return f[k / d];
   endfunction

   function automatic logic [31:0] status_exp(input bit busy, input int cnt, input bit ovf);
      logic [31:0] s;
      s    = 32'(cnt) << 4;
      s[0] = busy;
      s[1] = (cnt == DEPTH);
      s[2] = (cnt == 0);
      s[3] = ovf;
      return s;
   endfunction

   // Call just after the edge that makes the first pop due on the next edge.
   // Expects every queued byte as a 10*d-cycle frame followed by one idle cycle.
   task automatic check_tx(input int d);
      int n;
      byte unsigned b;
      n = exp_q.size();
      for (int j = 0; j < n; j++) begin
         b = exp_q.pop_front();
         for (int k = 0; k < 10 * d; k++) begin
            @(posedge clk); #1;
            chk($sformatf("txd f%0d c%0d", j, k), 32'(txd), 32'(frame_bit(b, k, d)));
            chk("irq_in_frame", 32'(IRQ), 32'd0);
            bus_rd(UART_STATUS, "status_busy", status_exp(1'b1, exp_q.size(), 1'b0));
         end
         @(posedge clk); #1;
         chk("txd_idle_gap", 32'(txd), 32'd1);
         bus_rd(UART_STATUS, "status_idle_gap", status_exp(1'b0, exp_q.size(), 1'b0));
      end
   endtask

   initial begin
      byte unsigned b, b2;
      int d;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_irq", 32'(IRQ), 32'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      bus_rd(UART_STATUS, "rst_status", 32'h4);
      bus_rd(UART_DIV, "rst_div", 32'd434);
      bus_rd(UART_CTRL, "rst_ctrl", 32'd0);
      bus_rd(UART_DATA, "rst_data", 32'd0);

      // register field masking
      bus_wr(UART_DIV, 32'hFFFF_0004);
      bus_rd(UART_DIV, "div_mask", 32'd4);
      bus_wr(UART_CTRL, 32'hFFFF_FFFC);
      bus_rd(UART_CTRL, "ctrl_mask", 32'd0);

      // single 0xA5 frame at divisor 4
      bus_wr(UART_CTRL, 32'd1);
      bus_rd(UART_CTRL, "ctrl_en", 32'd1);
      chk("irq_no_irq_en", 32'(IRQ), 32'd0);
      exp_q.push_back(8'hA5);
      bus_wr(UART_DATA, 32'h0000_00A5);
      chk("pre_pop_txd", 32'(txd), 32'd1);
      bus_rd(UART_STATUS, "pre_pop_status", status_exp(1'b0, 1, 1'b0));
      check_tx(4);
      bus_rd(UART_STATUS, "after_a5", 32'h4);

      // random bytes at random small divisors
      repeat (3) begin
         d = $urandom_range(1, 5);
         b = 8'($urandom);
         bus_wr(UART_DIV, 32'(d));
         exp_q.push_back(b);
         bus_wr(UART_DATA, {24'($urandom), b});
         check_tx(d);
      end

      // divisor 0 behaves as 1
      bus_wr(UART_DIV, 32'd0);
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_wr(UART_DATA, {24'd0, b});
      check_tx(1);

      // overflow with transmitter disabled
      bus_wr(UART_CTRL, 32'd0);
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         if (i < DEPTH) exp_q.push_back(b);
         bus_wr(UART_DATA, {24'($urandom), b});
         chk("txd_disabled", 32'(txd), 32'd1);
      end
      bus_rd(UART_STATUS, "ovf_status", status_exp(1'b0, DEPTH, 1'b1));
      bus_wr(UART_STATUS, $urandom);
      bus_rd(UART_STATUS, "ovf_cleared", status_exp(1'b0, DEPTH, 1'b0));

      // back-to-back frames draining the full FIFO at divisor 2
      bus_wr(UART_DIV, 32'd2);
      bus_wr(UART_CTRL, 32'd1);
      check_tx(2);
      bus_rd(UART_STATUS, "drained", 32'h4);

      // clearing enable mid-frame: frame completes, no further pop
      b  = 8'($urandom);
      b2 = 8'($urandom);
      bus_wr(UART_CTRL, 32'd0);
      bus_wr(UART_DATA, {24'd0, b});
      bus_wr(UART_DATA, {24'd0, b2});
      bus_wr(UART_CTRL, 32'd1);
      bus_wr(UART_CTRL, 32'd0);
      chk("en_clr c0", 32'(txd), 32'(frame_bit(b, 0, 2)));
      for (int k = 1; k < 20; k++) begin
         @(posedge clk); #1;
         chk($sformatf("en_clr c%0d", k), 32'(txd), 32'(frame_bit(b, k, 2)));
      end
      repeat (5) begin
         @(posedge clk); #1;
         chk("en_clr_idle_txd", 32'(txd), 32'd1);
      end
      bus_rd(UART_STATUS, "en_clr_status", status_exp(1'b0, 1, 1'b0));
      exp_q.push_back(b2);
      bus_wr(UART_CTRL, 32'd1);
      check_tx(2);

      // interrupt behaviour
      d = $urandom_range(1, 3);
      bus_wr(UART_DIV, 32'(d));
      bus_wr(UART_CTRL, 32'd3);
      chk("irq_idle_empty", 32'(IRQ), 32'd1);
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_wr(UART_DATA, {24'd0, b});
      chk("irq_drop_on_push", 32'(IRQ), 32'd0);
      check_tx(d);
      chk("irq_after_frame", 32'(IRQ), 32'd1);
      bus_wr(UART_CTRL, 32'd1);
      chk("irq_en_cleared", 32'(IRQ), 32'd0);
      bus_wr(UART_CTRL, 32'd2);
      chk("irq_needs_enable", 32'(IRQ), 32'd0);

      // reset during data bit 3 aborts the frame
      bus_wr(UART_DIV, 32'd3);
      bus_wr(UART_CTRL, 32'd1);
      b = 8'($urandom);
      bus_wr(UART_DATA, {24'd0, b});
      repeat (13) @(posedge clk);
      #1;
      chk("pre_rst_bit3", 32'(txd), 32'(frame_bit(b, 13, 3)));
      bus_rd(UART_STATUS, "pre_rst_busy", status_exp(1'b1, 0, 1'b0));
      @(negedge clk) reset = 1'b0;
      #1;
      chk("mid_rst_txd", 32'(txd), 32'd1);
      bus_rd(UART_STATUS, "mid_rst_status", 32'h4);
      bus_rd(UART_CTRL, "mid_rst_ctrl", 32'd0);
      bus_rd(UART_DIV, "mid_rst_div", 32'd434);
      @(negedge clk) reset = 1'b1;
      bus_wr(UART_DIV, 32'd3);
      b = 8'($urandom);
      bus_wr(UART_DATA, {24'd0, b});
      repeat (5) begin
         @(posedge clk); #1;
         chk("post_rst_no_tx", 32'(txd), 32'd1);
      end
      bus_rd(UART_STATUS, "post_rst_status", status_exp(1'b0, 1, 1'b0));
      exp_q.push_back(b);
      bus_wr(UART_CTRL, 32'd1);
      check_tx(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
Memory-mapped UART transmitter peripheral on the bridge's device side, alongside the two timers. The bridge drives its word address, write enable and write data, and muxes its read data back to the CPU. The block buffers bytes in a FIFO and serialises them 8N1 on txd. Its IRQ line feeds a spare HwInt bit (HwInt[3]).

Parameters:
FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..16
DIV_DEFAULT, 16'd434, reset value of DIVISOR in clk cycles per bit (50 MHz / 115200)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state
Addr  input  30  word address from bridge (byte addr [31:2]); only Addr[3:2] decoded
WE  input  1  write strobe from bridge, one cycle per store
Din  input  32  write data from bridge
Dout  output  32  read data to bridge, combinational from Addr[3:2] and registered state
txd  output  1  serial line, idle high
IRQ  output  1  level interrupt to CPU HwInt[3]

Behaviour:
- Register map, Addr[3:2]:
  - 0 DATA: write pushes Din[7:0] into the FIFO; reads 0.
  - 1 STATUS (read): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), [8:4] count. Any write clears overflow.
  - 2 CTRL (r/w): bit0 enable, bit1 irq_en; other bits read 0.
  - 3 DIVISOR (r/w): [15:0]; [31:16] read 0.
- Reset values: txd=1, IRQ=0, FIFO empty, count=0, overflow=0, CTRL=0, DIVISOR=DIV_DEFAULT, FSM=IDLE, bit counter=0. Reset mid-frame aborts the frame; txd returns to 1 asynchronously.
- FIFO:
  - Circular buffer with rd/wr pointers and a count of width clog2(FIFO_DEPTH)+1; pointers wrap at FIFO_DEPTH.
  - Push on WE & Addr==0. A push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A rejected push sets overflow and leaves the FIFO unchanged.
  - Simultaneous push and pop leaves count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If enable & !empty: pop head into an 8-bit shifter, clear the baud counter, go to START.
  - START: txd=0 for one bit time, then DATA.
  - DATA: txd=shifter[0], LSB first. Shift at each bit end. After 8 bits go to STOP.
  - STOP: txd=1 for one bit time, then IDLE. A back-to-back frame starts with the next IDLE cycle, so there is exactly one IDLE cycle between frames.
- Bit time:
  - Baud counter counts 0..DIVISOR-1; the bit ends when counter==DIVISOR-1. DIVISOR==0 is treated as 1.
  - A DIVISOR write mid-frame is compared live. If the counter already exceeds the new value-1, the bit ends on the next cycle.
- Latency: a DATA write at edge N makes FIFO non-empty after N. If IDLE and enabled, the pop happens at edge N+1 and txd falls after edge N+1. A full frame is 10*DIVISOR cycles.
- Clearing enable mid-frame: the current frame completes; no further pops occur.
- CTRL/DIVISOR writes take effect on the edge of WE; reads reflect the new value from the next cycle.
- IRQ = irq_en & enable & empty & (state==IDLE). Combinational from registers, so it is glitch-free relative to clk. Software clears it by pushing data or clearing irq_en.
- Dout is defined for all Addr values. Upper Addr bits are ignored; the bridge owns range decode.

Decomposition:
- Shared package: register offset constants (UART_DATA=2'd0, UART_STATUS=2'd1, UART_CTRL=2'd2, UART_DIV=2'd3), STATUS/CTRL bit positions, FSM state encoding, DIV_DEFAULT.
- One sub-module: uart_tx_fifo. Parameterised by FIFO_DEPTH; ports push/din/pop/dout/full/empty/count; async active-low reset.
- FSM, baud counter and register file stay in the top.

Test Plan:
- Reset then read STATUS and DIVISOR -> STATUS=0x00000004, DIVISOR=434, txd=1, IRQ=0.
- DIVISOR=4, CTRL=1, write DATA=0xA5 -> txd low 4 cycles starting the cycle after the pop. Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles. busy=1 throughout; STATUS=0x04 after.
- CTRL=0, write 9 bytes with FIFO_DEPTH=8 -> count=8, full=1, overflow=1, txd stays 1. Write STATUS, then read -> overflow=0, count=8.
- DIVISOR=2, CTRL=1 with 3 queued bytes -> three back-to-back frames of 20 cycles each, separated by exactly one idle cycle. count goes 3→2→1→0 at each pop.
- CTRL=3, one byte sent -> IRQ=0 during the frame and rises in the IDLE cycle after STOP with FIFO empty. Writing DATA drops IRQ on the next edge.
- Mid-frame (during DATA bit 3) assert reset low -> txd=1, STATUS=0x04 and CTRL=0 immediately; after release a fresh frame needs re-enable.
